// File: rtl/fb_pkg.sv
// Frame-capture shared definitions: frame geometry, address arithmetic, FSM
// state encoding and a saturating counter helper.
//   H_RES / V_RES : visible frame size (x 0..159, y 0..119)
//   FB_DEPTH      : number of pixels in the frame store
//   fb_addr()     : raster address y*160 + x built from shifts and an add
package fb_pkg;

    localparam int H_RES     = 160;
    localparam int V_RES     = 120;
    localparam int COLOUR_W  = 3;
    localparam int FB_DEPTH  = 19200;
    localparam int FB_ADDR_W = 15;
    localparam int X_W       = 8;
    localparam int Y_W       = 7;
    localparam int CNT_W     = 16;

    localparam logic [X_W-1:0]       X_LIM    = 8'd160;
    localparam logic [Y_W-1:0]       Y_LIM    = 7'd120;
    localparam logic [X_W-1:0]       X_END    = 8'd159;
    localparam logic [Y_W-1:0]       Y_END    = 7'd119;
    localparam logic [FB_ADDR_W-1:0] CLR_LAST = 15'd19199;
    localparam logic [CNT_W-1:0]     CNT_MAX  = 16'hFFFF;

    typedef enum logic [2:0] {
        CLEAR = 3'd0,
        IDLE  = 3'd1,
        FETCH = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } fc_state_t;

    // y*160 = y*128 + y*32; the widened y keeps the shifted terms from truncating.
    function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [X_W-1:0] x,
                                                     input logic [Y_W-1:0] y);
        logic [FB_ADDR_W-1:0] yy;
        yy = {8'd0, y};
        return (yy << 7) + (yy << 5) + {7'd0, x};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/frame_capture_if.sv
// Pixel-plot input and pixel-readout stream between a driver and frame_capture.
//   slave  : the capture block (receives plots, produces the readout stream)
//   master : whatever drives plots / requests readout and consumes pixels
interface frame_capture_if;
    import fb_pkg::*;

    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_plot;
    logic                init_done;
    logic                read_start;
    logic                read_done;
    logic [X_W-1:0]      rd_x;
    logic [Y_W-1:0]      rd_y;
    logic [COLOUR_W-1:0] rd_colour;
    logic                rd_valid;
    logic                rd_ready;
    logic [CNT_W-1:0]    plot_count;
    logic [CNT_W-1:0]    drop_count;

    modport slave (
        input  vga_x, vga_y, vga_colour, vga_plot, read_start, rd_ready,
        output init_done, read_done, rd_x, rd_y, rd_colour, rd_valid,
               plot_count, drop_count
    );

    modport master (
        output vga_x, vga_y, vga_colour, vga_plot, read_start, rd_ready,
        input  init_done, read_done, rd_x, rd_y, rd_colour, rd_valid,
               plot_count, drop_count
    );

endinterface

// File: rtl/frame_capture_fb_ram.sv
// fb_ram: simple dual-port frame store, FB_DEPTH x COLOUR_W.
//   clk, rst_n        : clock; reset clears only the read data register
//   we_i/waddr_i/wdata_i : synchronous write port
//   re_i/raddr_i      : read request; rdata_o is registered and holds when re_i=0
// A same-address write and read in one cycle returns the previous contents.
module fb_ram
    import fb_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we_i,
    input  logic [FB_ADDR_W-1:0] waddr_i,
    input  logic [COLOUR_W-1:0]  wdata_i,
    input  logic                 re_i,
    input  logic [FB_ADDR_W-1:0] raddr_i,
    output logic [COLOUR_W-1:0]  rdata_o
);

    logic [COLOUR_W-1:0] mem_q [FB_DEPTH];
    logic [COLOUR_W-1:0] rdata_q;

    // Storage array write; no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read, held between requests so the readout colour stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 3'd0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_capture.sv
// frame_capture: captures accepted pixel plots into a 160x120x3 frame store and
// replays the frame in raster order over a valid/ready stream.
//   clk, rst_n : clock, asynchronous active-low reset
//   fc (slave) : plot inputs (vga_*), init_done, readout handshake
//                (read_start/read_done, rd_* stream), plot/drop counters
// After reset the store is cleared one address per cycle; plots are accepted
// only once init_done is high. The write port runs independently of readout.
module frame_capture
    import fb_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    frame_capture_if.slave fc
);

    fc_state_t            state_q, state_d;
    logic [FB_ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [X_W-1:0]       scan_x_q, scan_x_d;
    logic [Y_W-1:0]       scan_y_q, scan_y_d;
    logic [X_W-1:0]       rd_x_q, rd_x_d;
    logic [Y_W-1:0]       rd_y_q, rd_y_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 read_done_q, read_done_d;
    logic                 init_done_q, init_done_d;
    logic [CNT_W-1:0]     plot_count_q, plot_count_d;
    logic [CNT_W-1:0]     drop_count_q, drop_count_d;

    logic                 plot_ok_s;
    logic                 ram_we_s;
    logic [FB_ADDR_W-1:0] ram_waddr_s;
    logic [COLOUR_W-1:0]  ram_wdata_s;
    logic                 ram_re_s;
    logic [FB_ADDR_W-1:0] ram_raddr_s;
    logic [COLOUR_W-1:0]  ram_rdata_s;

    assign plot_ok_s = fc.vga_plot & init_done_q &
                       (fc.vga_x < X_LIM) & (fc.vga_y < Y_LIM);

    // Write port: the clear sweep owns the RAM until init_done, then plots do.
    always_comb begin
        ram_we_s    = 1'b0;
        ram_waddr_s = clr_addr_q;
        ram_wdata_s = 3'd0;
        if (state_q == CLEAR) begin
            ram_we_s    = 1'b1;
            ram_waddr_s = clr_addr_q;
            ram_wdata_s = 3'd0;
        end else begin
            ram_we_s    = plot_ok_s;
            ram_waddr_s = fb_addr(fc.vga_x, fc.vga_y);
            ram_wdata_s = fc.vga_colour;
        end
    end

    // Read only in FETCH so the RAM output register holds the pixel through HOLD.
    assign ram_re_s    = (state_q == FETCH);
    assign ram_raddr_s = fb_addr(scan_x_q, scan_y_q);

    fb_ram u_fb_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (ram_we_s),
        .waddr_i (ram_waddr_s),
        .wdata_i (ram_wdata_s),
        .re_i    (ram_re_s),
        .raddr_i (ram_raddr_s),
        .rdata_o (ram_rdata_s)
    );

    // Next-state, scan counters and registered stream outputs.
    always_comb begin
        state_d     = state_q;
        clr_addr_d  = clr_addr_q;
        scan_x_d    = scan_x_q;
        scan_y_d    = scan_y_q;
        rd_x_d      = rd_x_q;
        rd_y_d      = rd_y_q;
        init_done_d = init_done_q;
        case (state_q)
            CLEAR: begin
                if (clr_addr_q == CLR_LAST) begin
                    clr_addr_d  = 15'd0;
                    init_done_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    clr_addr_d  = clr_addr_q + 15'd1;
                end
            end
            IDLE: begin
                scan_x_d = 8'd0;
                scan_y_d = 7'd0;
                if (fc.read_start) begin
                    state_d = FETCH;
                end else begin
                    state_d = IDLE;
                end
            end
            FETCH: begin
                rd_x_d  = scan_x_q;
                rd_y_d  = scan_y_q;
                state_d = HOLD;
            end
            HOLD: begin
                // rd_valid is always high in HOLD, so rd_ready alone completes the handshake.
                if (fc.rd_ready) begin
                    if (scan_x_q == X_END) begin
                        scan_x_d = 8'd0;
                        if (scan_y_q == Y_END) begin
                            state_d = DONE;
                        end else begin
                            scan_y_d = scan_y_q + 7'd1;
                            state_d  = FETCH;
                        end
                    end else begin
                        scan_x_d = scan_x_q + 8'd1;
                        state_d  = FETCH;
                    end
                end else begin
                    state_d = HOLD;
                end
            end
            DONE: begin
                if (fc.read_start) begin
                    state_d = DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d     = CLEAR;
                clr_addr_d  = 15'd0;
                init_done_d = 1'b0;
            end
        endcase
        // Flags follow the state being entered so they are registered with it.
        rd_valid_d  = (state_d == HOLD);
        read_done_d = (state_d == DONE);
    end

    // Saturating accept/drop counters.
    always_comb begin
        plot_count_d = plot_count_q;
        drop_count_d = drop_count_q;
        if (plot_ok_s) begin
            plot_count_d = sat_inc(plot_count_q);
        end else if (fc.vga_plot) begin
            drop_count_d = sat_inc(drop_count_q);
        end else begin
            plot_count_d = plot_count_q;
            drop_count_d = drop_count_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= CLEAR;
            clr_addr_q   <= 15'd0;
            scan_x_q     <= 8'd0;
            scan_y_q     <= 7'd0;
            rd_x_q       <= 8'd0;
            rd_y_q       <= 7'd0;
            rd_valid_q   <= 1'b0;
            read_done_q  <= 1'b0;
            init_done_q  <= 1'b0;
            plot_count_q <= 16'd0;
            drop_count_q <= 16'd0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            scan_x_q     <= scan_x_d;
            scan_y_q     <= scan_y_d;
            rd_x_q       <= rd_x_d;
            rd_y_q       <= rd_y_d;
            rd_valid_q   <= rd_valid_d;
            read_done_q  <= read_done_d;
            init_done_q  <= init_done_d;
            plot_count_q <= plot_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign fc.init_done  = init_done_q;
    assign fc.read_done  = read_done_q;
    assign fc.rd_x       = rd_x_q;
    assign fc.rd_y       = rd_y_q;
    assign fc.rd_colour  = ram_rdata_s;
    assign fc.rd_valid   = rd_valid_q;
    assign fc.plot_count = plot_count_q;
    assign fc.drop_count = drop_count_q;

endmodule

// File: tb/tb_frame_capture.sv
// Directed bench for frame_capture: clear timing, plot accept/drop, raster
// readout with back-pressure, reset abort, last-write-wins and repeat readout.
module tb_frame_capture;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic [2:0] pix [19200];
    logic [2:0] first_pix [32];
    int         got_n;
    int         order_errs;
    int         stall_errs;
    logic [7:0] last_x;
    logic [6:0] last_y;

    frame_capture_if fif ();

    frame_capture u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fc    (fif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic plot(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        fif.vga_x      = x;
        fif.vga_y      = y;
        fif.vga_colour = c;
        fif.vga_plot   = 1'b1;
        @(negedge clk);
        fif.vga_plot   = 1'b0;
    endtask

    // Called on the negedge where rst_n was just released; one plot is issued mid-clear.
    task automatic run_clear(input logic [15:0] exp_drop);
        check_val("init_low_start", 32'(fif.init_done), 32'd0);
        for (int c = 1; c <= 19199; c++) begin
            @(negedge clk);
            if (c == 100) begin
                fif.vga_x    = 8'd5;
                fif.vga_y    = 7'd5;
                fif.vga_plot = 1'b1;
            end else if (c == 101) begin
                fif.vga_plot = 1'b0;
            end
        end
        check_val("init_low_19199", 32'(fif.init_done), 32'd0);
        @(negedge clk);
        check_val("init_high_19200", 32'(fif.init_done), 32'd1);
        check_val("clear_drop", 32'(fif.drop_count), 32'(exp_drop));
        check_val("clear_plot", 32'(fif.plot_count), 32'd0);
    endtask

    // Streams up to n pixels; optional 5-cycle stall at pixel 10; optional reset at abort_at.
    task automatic read_pixels(input int n, input bit do_stall, input int abort_at);
        int         t;
        logic [7:0] sx;
        logic [6:0] sy;
        logic [2:0] sc;
        got_n      = 0;
        order_errs = 0;
        stall_errs = 0;
        t          = 0;
        fif.rd_ready   = 1'b1;
        fif.read_start = 1'b1;
        while (got_n < n && t < 2 * n + 100) begin
            @(negedge clk);
            t++;
            if (fif.rd_valid) begin
                if (got_n == abort_at) begin
                    rst_n = 1'b0;
                    #1;
                    check_val("rst_rd_valid",  32'(fif.rd_valid),   32'd0);
                    check_val("rst_rd_x",      32'(fif.rd_x),       32'd0);
                    check_val("rst_rd_y",      32'(fif.rd_y),       32'd0);
                    check_val("rst_rd_colour", 32'(fif.rd_colour),  32'd0);
                    check_val("rst_init_done", 32'(fif.init_done),  32'd0);
                    check_val("rst_plot_cnt",  32'(fif.plot_count), 32'd0);
                    check_val("rst_drop_cnt",  32'(fif.drop_count), 32'd0);
                    fif.read_start = 1'b0;
                    return;
                end
                if (do_stall && got_n == 10) begin
                    fif.rd_ready = 1'b0;
                    sx = fif.rd_x;
                    sy = fif.rd_y;
                    sc = fif.rd_colour;
                    repeat (5) begin
                        @(negedge clk);
                        if (fif.rd_valid !== 1'b1 || fif.rd_x !== sx ||
                            fif.rd_y !== sy || fif.rd_colour !== sc) begin
                            stall_errs++;
                        end
                    end
                    fif.rd_ready = 1'b1;
                end
                if (fif.rd_x !== 8'(got_n % 160) || fif.rd_y !== 7'(got_n / 160)) begin
                    order_errs++;
                end
                pix[got_n] = fif.rd_colour;
                last_x     = fif.rd_x;
                last_y     = fif.rd_y;
                got_n++;
            end
        end
    endtask

    initial begin
        int t;
        int nz;
        int errs;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        fif.vga_x      = 8'd0;
        fif.vga_y      = 7'd0;
        fif.vga_colour = 3'd0;
        fif.vga_plot   = 1'b0;
        fif.read_start = 1'b0;
        fif.rd_ready   = 1'b0;

        @(negedge clk);
        check_val("reset_init_done", 32'(fif.init_done),  32'd0);
        check_val("reset_rd_valid",  32'(fif.rd_valid),   32'd0);
        check_val("reset_read_done", 32'(fif.read_done),  32'd0);
        check_val("reset_plot_cnt",  32'(fif.plot_count), 32'd0);
        rst_n = 1'b1;
        run_clear(16'd1);

        // Phase A: plot two pixels, read part of the frame, reset at pixel 500.
        plot(8'd5, 7'd0, 3'b110);
        plot(8'd80, 7'd60, 3'b010);
        check_val("a_plot_cnt", 32'(fif.plot_count), 32'd2);
        check_val("a_drop_cnt", 32'(fif.drop_count), 32'd1);
        read_pixels(19200, 1'b0, 500);
        check_val("a_got_n",   32'(got_n),      32'd500);
        check_val("a_order",   32'(order_errs), 32'd0);
        check_val("a_pix0",    32'(pix[0]),     32'd0);
        check_val("a_pix5",    32'(pix[5]),     32'd6);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_clear(16'd1);

        // Phase B: drops, last-write-wins, full readout with back-pressure.
        plot(8'd160, 7'd5, 3'b111);
        plot(8'd3, 7'd120, 3'b111);
        plot(8'd80, 7'd60, 3'b010);
        plot(8'd0, 7'd0, 3'b111);
        plot(8'd0, 7'd0, 3'b111);
        plot(8'd0, 7'd0, 3'b001);
        check_val("b_plot_cnt", 32'(fif.plot_count), 32'd4);
        check_val("b_drop_cnt", 32'(fif.drop_count), 32'd3);
        read_pixels(19200, 1'b1, -1);
        check_val("b_got_n",   32'(got_n),      32'd19200);
        check_val("b_order",   32'(order_errs), 32'd0);
        check_val("b_stall",   32'(stall_errs), 32'd0);
        check_val("b_last_x",  32'(last_x),     32'd159);
        check_val("b_last_y",  32'(last_y),     32'd119);
        check_val("b_pix0",    32'(pix[0]),     32'd1);
        check_val("b_pix9680", 32'(pix[9680]),  32'd2);
        check_val("b_pix5_lost", 32'(pix[5]),   32'd0);
        nz = 0;
        for (int i = 0; i < 19200; i++) begin
            if (pix[i] !== 3'd0) nz++;
        end
        check_val("b_nonzero", 32'(nz), 32'd2);

        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (fif.read_done !== 1'b1 && t < 8);
        check_val("b_read_done", 32'(fif.read_done), 32'd1);
        errs = 0;
        repeat (5) begin
            @(negedge clk);
            if (fif.read_done !== 1'b1 || fif.rd_valid !== 1'b0) errs++;
        end
        check_val("b_done_hold", 32'(errs), 32'd0);
        fif.read_start = 1'b0;
        @(negedge clk);
        check_val("b_done_clr", 32'(fif.read_done), 32'd0);

        for (int i = 0; i < 32; i++) first_pix[i] = pix[i];
        read_pixels(32, 1'b0, -1);
        check_val("c_got_n", 32'(got_n),      32'd32);
        check_val("c_order", 32'(order_errs), 32'd0);
        errs = 0;
        for (int i = 0; i < 32; i++) begin
            if (pix[i] !== first_pix[i]) errs++;
        end
        check_val("c_repeat", 32'(errs), 32'd0);
        fif.read_start = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
